// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed BCD 7-segment driver with double-buffered digits, dp, blink and frame strobe
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   digits_in       BCD digits, digit k = bits [4k+3:4k], digit 0 least significant
//   dp_in           decimal-point request per digit, captured with digits_in
//   load            capture digits_in/dp_in into the pending buffer
//   blink_mask      digits to blink, sampled live
//   seg             segments {g,f,e,d,c,b,a}, active-high
//   dp              decimal point of the lit digit, active-high
//   an              one-hot digit enable, active-high
//   frame_done      one-cycle pulse registered with the last digit's final slot cycle
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros above digit 0 (dp still shown).
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] pend, disp;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend_valid;
  logic                    slot_end, wrap, blink_wrap;
  logic [3:0]              dig [NUM_DIGITS];
  logic [3:0]              code;
  logic                    bad, blink_off, lzb;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  genvar i;
  for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign dig[i] = disp[4*i +: 4];
  end
`ifdef LEADING_ZERO_BLANK_EN
  // zhi[k]: digit k and every digit above it are zero
  logic [NUM_DIGITS-1:0] zhi;
  for (i = 0; i < NUM_DIGITS; i++) begin : g_lz
    if (i == NUM_DIGITS - 1) begin : g_top
      assign zhi[i] = dig[i] == 4'd0;
    end else begin : g_mid
      assign zhi[i] = dig[i] == 4'd0 && zhi[i+1];
    end
  end
  assign lzb = scan_idx != '0 && zhi[scan_idx];
`else
  assign lzb = 1'b0;
`endif
  always_comb begin
    slot_end   = scan_cnt == SW'(SCAN_DIV - 1);
    wrap       = slot_end && scan_idx == IW'(NUM_DIGITS - 1);
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    code       = dig[scan_idx];
    bad        = code > 4'd9;
    blink_off  = blink_phase && blink_mask[scan_idx];
    seg_n      = (bad || blink_off || lzb) ? 7'h00 : SEG_LUT[code];
    dp_n       = disp_dp[scan_idx] && !bad && !blink_off;
    an_n       = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      disp        <= '0;
      disp_dp     <= '0;
      seg         <= '0;
      dp          <= 1'b0;
      an          <= '0;
      frame_done  <= 1'b0;
    end else begin
      scan_cnt  <= slot_end ? '0 : scan_cnt + 1'b1;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (slot_end) scan_idx <= wrap ? '0 : scan_idx + 1'b1;
      if (blink_wrap) blink_phase <= ~blink_phase;
      if (load) begin
        pend    <= digits_in;
        pend_dp <= dp_in;
      end
      // a load coinciding with the frame boundary bypasses pending entirely
      if (wrap) begin
        disp       <= load ? digits_in : pend_valid ? pend : disp;
        disp_dp    <= load ? dp_in : pend_valid ? pend_dp : disp_dp;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end
      seg        <= seg_n;
      dp         <= dp_n;
      an         <= an_n;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench for seg7_scan_driver against a time-based reference model
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BD = 64;
  localparam int FR = N * SD;
  localparam logic [6:0] TBL [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } obs_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  obs_t        q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          e = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_ddp = '0, m_pdp = '0;
  bit          m_pv = 1'b0;
  logic [3:0]  cur_bm = '0;
  seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] p);
    obs_t x;
    int idx;
    logic [3:0] v;
    bit blk, lz, wr;
    @(negedge clk);
    rst = r;
    load = ld;
    digits_in = d;
    dp_in = p;
    blink_mask = cur_bm;
    x = '0;
    if (r) begin
      e = 0;
      m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      idx = (e / SD) % N;
      v = m_disp[4*idx +: 4];
      blk = ((e / BD) % 2 == 1) && cur_bm[idx];
      lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0) begin
        lz = 1'b1;
        for (int k = idx; k < N; k++) if (m_disp[4*k +: 4] != 4'd0) lz = 1'b0;
      end
`endif
      wr = (e % FR) == FR - 1;
      x.seg = (v > 9 || blk || lz) ? 7'b0 : TBL[v];
      x.dp = m_ddp[idx] && v <= 9 && !blk;
      x.an = 4'(1 << idx);
      x.fd = wr;
      if (ld) begin m_pend = d; m_pdp = p; end
      if (wr) begin
        if (ld) begin m_disp = d; m_ddp = p; end
        else if (m_pv) begin m_disp = m_pend; m_ddp = m_pdp; end
        m_pv = 1'b0;
      end else if (ld) m_pv = 1'b1;
      e++;
    end
    q.push_back(x);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask
  task automatic run_to(input int pos);
    for (int i = 0; i < FR && (e % FR) != pos; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask
  initial begin
    obs_t x, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        got = {seg, dp, an, frame_done};
        vectors++;
        if (got !== x) begin
          miscompares++;
          $display("FAIL outputs @%0t: got seg=%b dp=%b an=%b fd=%b, expected seg=%b dp=%b an=%b fd=%b",
                   $time, got.seg, got.dp, got.an, got.fd, x.seg, x.dp, x.an, x.fd);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
    idle(40);
    step(1'b0, 1'b1, 16'h1259, 4'b0100);
    idle(40);
    run_to(3);
    step(1'b0, 1'b1, 16'h1234, 4'b0001);
    run_to(10);
    step(1'b0, 1'b1, 16'h5678, 4'b1000);
    idle(40);
    run_to(FR - 1);
    step(1'b0, 1'b1, 16'h4321, 4'b0010);
    idle(20);
    cur_bm = 4'b0001;
    run_to(FR - 1);
    step(1'b0, 1'b1, 16'hFA00, 4'b1111);
    idle(200);
    cur_bm = 4'b0000;
    run_to(2 * SD);
    step(1'b1, 1'b0, '0, '0);
    idle(40);
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++) d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 49) == 0) cur_bm = 4'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, d, 4'($urandom));
    end
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d outputs left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
